// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sharing of one 8-lane DRAM byte port among NUM_REQ requesters.
// Latency: req_en capture edge + grant edge, then a one-cycle dram_en pulse; responses routed back combinationally.
// Backpressure: one outstanding request per requester; req_en while busy is dropped and flagged on req_ovr.
// Optional WAIT timeout and timeout_err port: define DRAM_PORT_ARBITER_TIMEOUT_EN.
module dram_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ),
    parameter int TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0][7:0]         req_en,
    input  logic [NUM_REQ-1:0]              req_rdwr,
    input  logic [NUM_REQ-1:0][7:0][63:0]   req_addr,
    input  logic [NUM_REQ-1:0][7:0][7:0]    req_wdata,
    output logic [NUM_REQ-1:0][7:0]         req_valid,
    output logic [NUM_REQ-1:0][7:0][7:0]    req_data,
    output logic [NUM_REQ-1:0]              req_busy,
    output logic [NUM_REQ-1:0]              req_ovr,
    output logic [7:0]                      dram_en,
    output logic                            dram_rdwr,
    output logic [7:0][63:0]                dram_addr,
    output logic [7:0][7:0]                 dram_wdata,
    input  logic [7:0]                      dram_valid,
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    output logic                            timeout_err,
`endif
    input  logic [7:0][7:0]                 dram_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic [7:0]         mask;
        logic               rdwr;
        logic [7:0][63:0]   addr;
        logic [7:0][7:0]    wdata;
    } slot_t;

    state_t             state, state_nxt;
    slot_t              slots [NUM_REQ];
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] slot_clr, capture, overrun;
    logic [PTR_W-1:0]   rr_ptr, owner, owner_inc, grant_idx, search_idx;
    logic               grant_vld, done, release_owner;
    logic [7:0]         owner_mask;

    assign owner_mask = slots[owner].mask;
    assign done       = (state == WAIT) && ((dram_valid & owner_mask) == owner_mask);
    assign owner_inc  = (owner == PTR_W'(NUM_REQ-1)) ? '0 : owner + PTR_W'(1);

`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // A completion in the same cycle as the limit wins over the timeout.
    assign timed_out     = (state == WAIT) && !done && (wait_cnt == CNT_W'(TIMEOUT));
    assign timeout_err   = timed_out;
    assign release_owner = done || timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign release_owner = done;
`endif

    // Circular search for the first pending slot at or after rr_ptr.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && pending[search_idx]) begin
                grant_vld = 1'b1;
                grant_idx = search_idx;
            end
            search_idx = (search_idx == PTR_W'(NUM_REQ-1)) ? '0 : search_idx + PTR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (release_owner) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A slot released on this edge may take a new request on the same edge.
    always_comb begin
        slot_clr = '0;
        capture  = '0;
        overrun  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_clr[i] = release_owner && (owner == PTR_W'(i));
            capture[i]  = (|req_en[i]) && (!pending[i] || slot_clr[i]);
            overrun[i]  = (|req_en[i]) && pending[i] && !slot_clr[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                slots[i] <= '{mask: req_en[i], rdwr: req_rdwr[i], addr: req_addr[i], wdata: req_wdata[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            req_ovr    <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            dram_en    <= '0;
            dram_rdwr  <= 1'b1;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            pending <= (pending & ~slot_clr) | capture;
            req_ovr <= overrun;
            dram_en <= '0;
            if (state == IDLE && grant_vld) begin
                owner      <= grant_idx;
                dram_en    <= slots[grant_idx].mask;
                dram_rdwr  <= slots[grant_idx].rdwr;
                dram_addr  <= slots[grant_idx].addr;
                dram_wdata <= slots[grant_idx].wdata;
            end
            if (release_owner) begin
                rr_ptr <= owner_inc;
            end
        end
    end

    // Only the current owner sees DRAM responses; nothing is routed in IDLE.
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_busy  = pending;
        if (state != IDLE) begin
            req_valid[owner] = dram_valid;
            req_data[owner]  = dram_data;
            req_busy[owner]  = 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: expected DRAM issues are queued at request time and checked when dram_en fires.
// Define DRAM_PORT_ARBITER_TIMEOUT_EN for both files to include the timeout scenario.
module tb_dram_port_arbiter;

    typedef struct packed {
        logic [7:0]         en;
        logic               rdwr;
        logic [7:0][63:0]   addr;
        logic [7:0][7:0]    wdata;
    } issue_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [1:0][7:0]        req_en = '0;
    logic [1:0]             req_rdwr = '0;
    logic [1:0][7:0][63:0]  req_addr = '0;
    logic [1:0][7:0][7:0]   req_wdata = '0;
    logic [1:0][7:0]        req_valid;
    logic [1:0][7:0][7:0]   req_data;
    logic [1:0]             req_busy;
    logic [1:0]             req_ovr;
    logic [7:0]             dram_en;
    logic                   dram_rdwr;
    logic [7:0][63:0]       dram_addr;
    logic [7:0][7:0]        dram_wdata;
    logic [7:0]             dram_valid = '0;
    logic [7:0][7:0]        dram_data = '0;
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    logic                   timeout_err;
`endif

    issue_t exp_q[$];
    issue_t obs;
    issue_t exp_i;
    int     waited;
    int     tests = 0;
    int     fails = 0;

    dram_port_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_en     (req_en),
        .req_rdwr   (req_rdwr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_busy   (req_busy),
        .req_ovr    (req_ovr),
        .dram_en    (dram_en),
        .dram_rdwr  (dram_rdwr),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_valid (dram_valid),
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .dram_data  (dram_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic issue_t pop_exp();
        issue_t e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Drive a request for one cycle starting now; optionally record the DRAM issue it must produce.
    task automatic drive_req(input int r, input logic [7:0] en, input logic rdwr,
                             input logic [63:0] base, input logic [7:0] wbase, input bit push);
        issue_t e;
        e.en   = en;
        e.rdwr = rdwr;
        for (int l = 0; l < 8; l++) begin
            e.addr[l]  = base + 64'(l);
            e.wdata[l] = wbase + 8'(l);
        end
        req_en[r]    = en;
        req_rdwr[r]  = rdwr;
        req_addr[r]  = e.addr;
        req_wdata[r] = e.wdata;
        if (push) exp_q.push_back(e);
    endtask

    // Step negedges (clearing one-cycle stimulus) until dram_en fires; waited=0 if it never does.
    task automatic wait_issue(input int budget, output int w, output issue_t o);
        bit seen;
        seen = 1'b0;
        w    = 0;
        o    = '0;
        for (int k = 1; k <= budget && !seen; k++) begin
            @(negedge clk);
            req_en     = '0;
            dram_valid = '0;
            dram_data  = '0;
            if (dram_en != 8'h00) begin
                seen = 1'b1;
                w    = k;
                o    = '{en: dram_en, rdwr: dram_rdwr, addr: dram_addr, wdata: dram_wdata};
            end
        end
    endtask

    // One grant: check the issue against the queue and latency, then complete it with all lanes.
    task automatic serve(input int r, input int lat, input string tag);
        logic [7:0][7:0] d;
        wait_issue(8, waited, obs);
        exp_i = pop_exp();
        tests++;
        if (obs !== exp_i || waited != lat) begin
            fails++;
            $display("FAIL %s_issue: got lat=%0d en=%h addr0=%h, want lat=%0d en=%h addr0=%h",
                     tag, waited, obs.en, obs.addr[0], lat, exp_i.en, exp_i.addr[0]);
        end
        @(negedge clk);
        for (int l = 0; l < 8; l++) d[l] = 8'(17 * (l + 1)) ^ 8'(r);
        dram_data  = d;
        dram_valid = 8'hFF;
        #1;
        tests++;
        if (req_valid[r] !== 8'hFF || req_data[r] !== d || req_valid[1-r] !== 8'h00 || req_data[1-r] !== 64'h0) begin
            fails++;
            $display("FAIL %s_route: got valid=%h data0=%h data1=%h, want owner %0d valid FF data %h",
                     tag, req_valid, req_data[0], req_data[1], r, d);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        tests++;
        if ({dram_en, dram_rdwr, dram_addr, dram_wdata} !== {8'h00, 1'b1, 512'h0, 64'h0}) begin
            fails++;
            $display("FAIL reset_dram: got en=%h rdwr=%b addr0=%h wdata=%h, want 0/1/0/0",
                     dram_en, dram_rdwr, dram_addr[0], dram_wdata);
        end
        tests++;
        if ({req_busy, req_ovr, req_valid, req_data} !== '0) begin
            fails++;
            $display("FAIL reset_req: got busy=%b ovr=%b valid=%h, want all 0", req_busy, req_ovr, req_valid);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        drive_req(0, 8'hFF, 1'b1, 64'h100, 8'h00, 1'b1);
        serve(0, 2, "single");
        tests++;
        if (req_busy !== 2'b01) begin
            fails++;
            $display("FAIL single_busy_wait: got %b, want 01", req_busy);
        end
        @(negedge clk);
        dram_valid = '0;
        dram_data  = '0;
        tests++;
        if (req_busy !== 2'b00 || req_valid !== 16'h0) begin
            fails++;
            $display("FAIL single_done: got busy=%b valid=%h, want 00/0000", req_busy, req_valid);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drive_req(0, 8'hFF, 1'b1, 64'h200, 8'h00, 1'b1);
        drive_req(1, 8'hFF, 1'b0, 64'h300, 8'hA0, 1'b1);
        serve(0, 2, "sim_a0");
        serve(1, 2, "sim_a1");
        // One transaction for requester 0 leaves the pointer at 1.
        @(negedge clk);
        dram_valid = '0;
        drive_req(0, 8'hFF, 1'b1, 64'h400, 8'h00, 1'b1);
        serve(0, 2, "rr_pre0");
        @(negedge clk);
        dram_valid = '0;
        drive_req(1, 8'hFF, 1'b1, 64'h480, 8'h00, 1'b1);
        drive_req(0, 8'hFF, 1'b0, 64'h4C0, 8'h30, 1'b1);
        serve(1, 2, "sim_b1");
        serve(0, 2, "sim_b0");
        @(negedge clk);
        dram_valid = '0;
    endtask

    task automatic test_overrun();
        drive_req(1, 8'hFF, 1'b1, 64'h500, 8'h00, 1'b1);
        @(negedge clk);
        drive_req(1, 8'hFF, 1'b0, 64'h900, 8'h55, 1'b0);
        wait_issue(1, waited, obs);
        exp_i = pop_exp();
        tests++;
        if (req_ovr !== 2'b10) begin
            fails++;
            $display("FAIL ovr_pulse: got %b, want 10", req_ovr);
        end
        tests++;
        if (obs !== exp_i) begin
            fails++;
            $display("FAIL ovr_issue: got en=%h addr0=%h, want en=%h addr0=%h",
                     obs.en, obs.addr[0], exp_i.en, exp_i.addr[0]);
        end
        @(negedge clk);
        dram_valid = 8'hFF;
        #1;
        tests++;
        if (req_ovr !== 2'b00 || req_valid[1] !== 8'hFF) begin
            fails++;
            $display("FAIL ovr_clear: got ovr=%b valid1=%h, want 00/FF", req_ovr, req_valid[1]);
        end
        wait_issue(8, waited, obs);
        tests++;
        if (waited != 0 || req_busy !== 2'b00) begin
            fails++;
            $display("FAIL ovr_dropped: got extra issue lat=%0d addr0=%h busy=%b, want none", waited, obs.addr[0], req_busy);
        end
    endtask

    task automatic test_partial();
        drive_req(0, 8'h0F, 1'b0, 64'h700, 8'hC0, 1'b1);
        wait_issue(8, waited, obs);
        exp_i = pop_exp();
        tests++;
        if (obs !== exp_i || waited != 2) begin
            fails++;
            $display("FAIL part_issue: got lat=%0d en=%h wdata=%h, want lat=2 en=%h wdata=%h",
                     waited, obs.en, obs.wdata, exp_i.en, exp_i.wdata);
        end
        @(negedge clk);
        dram_valid = 8'hF3;
        #1;
        tests++;
        if (req_valid[0] !== 8'hF3) begin
            fails++;
            $display("FAIL part_route: got %h, want F3", req_valid[0]);
        end
        @(negedge clk);
        tests++;
        if (req_busy !== 2'b01) begin
            fails++;
            $display("FAIL part_not_done: got busy=%b, want 01", req_busy);
        end
        dram_valid = 8'h0F;
        @(negedge clk);
        dram_valid = '0;
        tests++;
        if (req_busy !== 2'b00 || dram_addr !== exp_i.addr || dram_wdata !== exp_i.wdata || dram_rdwr !== 1'b0) begin
            fails++;
            $display("FAIL part_done_hold: got busy=%b addr0=%h wdata=%h rdwr=%b, want 00 %h %h 0",
                     req_busy, dram_addr[0], dram_wdata, dram_rdwr, exp_i.addr[0], exp_i.wdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive_req(0, 8'hFF, 1'b1, 64'h800, 8'h00, 1'b1);
        wait_issue(8, waited, obs);
        exp_i = pop_exp();
        tests++;
        if (obs !== exp_i) begin
            fails++;
            $display("FAIL rst_issue: got addr0=%h, want %h", obs.addr[0], exp_i.addr[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        dram_valid = 8'hFF;
        dram_data  = 64'h0123456789ABCDEF;
        #1;
        tests++;
        if ({dram_en, dram_rdwr, dram_addr, dram_wdata, req_busy, req_valid, req_data} !==
            {8'h00, 1'b1, 512'h0, 64'h0, 2'b00, 16'h0, 128'h0}) begin
            fails++;
            $display("FAIL rst_mid: got en=%h rdwr=%b addr0=%h busy=%b valid=%h, want reset values",
                     dram_en, dram_rdwr, dram_addr[0], req_busy, req_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (req_valid !== 16'h0) begin
            fails++;
            $display("FAIL rst_late_resp: got valid=%h, want 0000", req_valid);
        end
        wait_issue(6, waited, obs);
        tests++;
        if (waited != 0) begin
            fails++;
            $display("FAIL rst_no_issue: got issue lat=%0d, want none", waited);
        end
    endtask

`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int hit;
        apply_reset();
        drive_req(0, 8'hFF, 1'b1, 64'hA00, 8'h00, 1'b1);
        drive_req(1, 8'hFF, 1'b1, 64'hB00, 8'h00, 1'b1);
        wait_issue(8, waited, obs);
        exp_i = pop_exp();
        tests++;
        if (obs !== exp_i) begin
            fails++;
            $display("FAIL to_issue0: got addr0=%h, want %h", obs.addr[0], exp_i.addr[0]);
        end
        hit = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                hit = k;
                break;
            end
        end
        tests++;
        if (hit != 17 || req_valid !== 16'h0) begin
            fails++;
            $display("FAIL to_pulse: got at negedge %0d valid=%h, want 17 after issue, valid 0000", hit, req_valid);
        end
        @(negedge clk);
        tests++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL to_width: got timeout_err=%b, want 0", timeout_err);
        end
        serve(1, 1, "to_next1");
        @(negedge clk);
        dram_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_overrun();
        test_partial();
        test_reset_mid_wait();
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d unissued, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
